rr_hold_arbiter: RTL and testbench
==================================

Name: rr_hold_arbiter

Overview:
- Parametrised round-robin arbiter for the router switch control. Arbitrates NPORT input requests for one output.
- The grant is held until the winning port releases it. Optional hold-timeout forces re-arbitration.
- Optional fixed-priority mode.
- Adds registered one-hot and encoded grants and back-to-back re-arbitration, so a new grant can issue in the cycle after release.

Parameters:
- NPORT, 5, number of requesting ports (>=2).
- PTR_W, $clog2(NPORT), width of encoded grant/pointer.
- MODE, 0, 0 = round robin, 1 = fixed priority (lowest index wins).
- MAX_HOLD, 0, 0 = unlimited hold; N>0 = grant forcibly ended after N cycles.
- CNT_W, $clog2(MAX_HOLD+2), hold counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- requests  in  NPORT  per-port request level.
- enable  in  1  arbitration permitted this cycle.
- release  in  1  current owner ends its grant (e.g. tail flit sent).
- grant_valid  out  1  a grant is held.
- grant_onehot  out  NPORT  one-hot owner; all zero when grant_valid=0.
- grant_idx  out  PTR_W  encoded owner; holds last value when grant_valid=0.
- timeout  out  1  one-cycle pulse when MAX_HOLD forced the release.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, grant_valid=0, grant_onehot=0, grant_idx=0, timeout=0, hold_cnt=0.
  - lastport=NPORT-1, so port 0 has first priority after reset.
- States:
  - IDLE: no grant held.
  - GRANT: grant held, outputs stable.
- Winner search (combinational, evaluated only when arbitration fires):
  - MODE=0: scan ports lastport+1, lastport+2, ... wrapping NPORT-1 -> 0, with lastport itself checked last. First asserted request wins.
  - MODE=1: scan from 0 upward. lastport is still updated but ignored.
- Arbitration fires at a rising edge when:
  - state=IDLE, enable=1 and |requests=1; or
  - state=GRANT with end_cond true, enable=1 and |requests=1.
- On fire, registered and visible the next cycle:
  - grant_valid=1, grant_onehot=1<<w, grant_idx=w, lastport=w, hold_cnt=0, state=GRANT.
  - Latency is one cycle from request/enable sample to grant.
- end_cond in GRANT is any of:
  - release=1;
  - requests[grant_idx]=0;
  - MAX_HOLD>0 and hold_cnt==MAX_HOLD-1.
- GRANT with end_cond false:
  - Outputs unchanged; hold_cnt+1, saturating at MAX_HOLD.
  - enable and other requests are ignored.
- GRANT with end_cond true and no fire:
  - Next cycle grant_valid=0, grant_onehot=0, state=IDLE. grant_idx and lastport are retained.
- Back-to-back: with end_cond true and a fire, the new winner's grant appears the next cycle with no bubble. The releasing port, if still requesting, is checked last in MODE=0.
- timeout:
  - Pulses 1 in the cycle after end_cond was caused solely by the hold limit, i.e. release=0 and the owner's request still high.
  - 0 otherwise.
- Simultaneous release and the owner's own request held: treated as a release. The owner only wins again if no other port requests (MODE=0).
- enable=0 in IDLE: no grant, pointer frozen.
- Reset asserted during GRANT drops all outputs immediately (async). Arbitration restarts from port 0 priority.
- Requests of non-winning ports are never acknowledged or latched. The arbiter holds no request state.

Test Plan:
- Reset, then requests=5'b10110, enable=1 for 1 cycle -> next cycle grant_idx=1, grant_onehot=5'b00010, grant_valid=1.
- Hold: keep requests=5'b10110, release=0 for 10 cycles (MAX_HOLD=0) -> grant_idx stays 1 throughout.
- Rotation: with requests=5'b10110 and enable held, pulse release each grant -> grant_idx sequence 1,2,4,1,2 with no idle cycle between grants.
- Owner drops request: grant to port 2 and requests[2] falls with no others pending -> next cycle grant_valid=0, grant_onehot=0, grant_idx stays 2. Then requests=5'b00100 -> port 2 granted again.
- Timeout: MAX_HOLD=4, requests=5'b00011, release=0 -> port 0 held 4 cycles, timeout pulses, port 1 granted the same cycle. Then port 0 after 4 more cycles.
- MODE=1 with requests=5'b11000 then 5'b11001 after release -> grants 3 then 0. Also assert reset mid-GRANT -> grant_valid=0 immediately, and after reset requests=5'b11111 -> grant_idx=0.

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin (or fixed-priority) arbiter granting one output
// to one of NPORT requesters. The grant is held until the owner releases it,
// drops its request, or an optional hold limit expires. Re-arbitration is
// back-to-back, so a new owner can be granted in the cycle after a release.
//
// Ports:
//   clock          in   rising-edge system clock
//   reset          in   asynchronous active-low reset
//   requests       in   per-port request levels [NPORT]
//   enable         in   arbitration permitted this cycle
//   owner_release  in   current owner ends its grant. "release" is a reserved
//                       word in SystemVerilog, so the port carries this name.
//   grant_valid    out  a grant is held
//   grant_onehot   out  one-hot owner, all zero when grant_valid=0
//   grant_idx      out  encoded owner, keeps its last value when idle
//   timeout        out  one-cycle pulse after the hold limit forced a release
module rr_hold_arbiter #(
  parameter int unsigned NPORT    = 5,
  parameter int unsigned PTR_W    = $clog2(NPORT),
  parameter int unsigned MODE     = 0,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NPORT-1:0] requests,
  input  logic             enable,
  input  logic             owner_release,
  output logic             grant_valid,
  output logic [NPORT-1:0] grant_onehot,
  output logic [PTR_W-1:0] grant_idx,
  output logic             timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               grant_valid_q, grant_valid_d;
  logic [NPORT-1:0]   grant_onehot_q, grant_onehot_d;
  logic [PTR_W-1:0]   grant_idx_q, grant_idx_d;
  logic               timeout_q, timeout_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               any_req;
  logic               owner_req;
  logic               limit_hit;
  logic               end_cond;
  logic               fire;
  logic [PTR_W-1:0]   win_idx;

  // Winner search. Round robin scans last+1 .. last (last checked at the
  // end); fixed priority scans from port 0 and ignores the pointer.
  function automatic logic [PTR_W-1:0] pick_winner(
    input logic [NPORT-1:0] req,
    input logic [PTR_W-1:0] last
  );
    logic [PTR_W-1:0] w;
    logic             found;
    int unsigned      cand;
    w     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (MODE == 1) begin
        cand = i;
      end else begin
        cand = (32'(last) + 32'd1 + i) % NPORT;
      end
      if (!found && req[PTR_W'(cand)]) begin
        found = 1'b1;
        w     = PTR_W'(cand);
      end
    end
    return w;
  endfunction

  // Grant-ending and arbitration-firing conditions.
  always_comb begin
    any_req   = |requests;
    owner_req = requests[grant_idx_q];
    limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    end_cond  = (state_q == S_GRANT) && (owner_release || !owner_req || limit_hit);
    fire      = enable && any_req && ((state_q == S_IDLE) || end_cond);
    win_idx   = pick_winner(requests, last_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_onehot_d = grant_onehot_q;
    grant_idx_d    = grant_idx_q;
    last_d         = last_q;
    hold_cnt_d     = hold_cnt_q;
    timeout_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fire) begin
          state_d        = S_GRANT;
          grant_valid_d  = 1'b1;
          grant_onehot_d = NPORT'(1) << win_idx;
          grant_idx_d    = win_idx;
          last_d         = win_idx;
          hold_cnt_d     = '0;
        end
      end

      S_GRANT: begin
        if (end_cond) begin
          // Pulse only when the hold limit alone ended the grant.
          timeout_d = limit_hit && !owner_release && owner_req;
          if (fire) begin
            grant_valid_d  = 1'b1;
            grant_onehot_d = NPORT'(1) << win_idx;
            grant_idx_d    = win_idx;
            last_d         = win_idx;
            hold_cnt_d     = '0;
          end else begin
            state_d        = S_IDLE;
            grant_valid_d  = 1'b0;
            grant_onehot_d = '0;
          end
        end else if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d        = S_IDLE;
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
      end
    endcase
  end

  // State and output registers; pointer resets so port 0 wins first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      grant_idx_q    <= '0;
      timeout_q      <= 1'b0;
      last_q         <= PTR_W'(NPORT - 1);
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
      grant_idx_q    <= grant_idx_d;
      timeout_q      <= timeout_d;
      last_q         <= last_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_idx    = grant_idx_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: three instances (round robin unlimited hold,
// round robin with hold limit 4, fixed priority) share one stimulus stream and
// are each checked every cycle against a behavioural owner/pointer model,
// plus literal expectations for the directed scenarios.
module tb_rr_hold_arbiter;

  localparam int NP = 5;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] requests = '0;
  logic          enable = 1'b0;
  logic          rel = 1'b0;

  logic          gv   [NI];
  logic [NP-1:0] goh  [NI];
  logic [2:0]    gidx [NI];
  logic          gto  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // model state per instance
  int m_owner [NI];
  int m_last  [NI];
  int m_idx   [NI];
  int m_held  [NI];
  bit m_to    [NI];

  always #5 clk = ~clk;

  rr_hold_arbiter #(.NPORT(NP), .MODE(0), .MAX_HOLD(0)) u_rr (
    .clock(clk), .reset(rst_n), .requests(requests), .enable(enable),
    .owner_release(rel), .grant_valid(gv[0]), .grant_onehot(goh[0]),
    .grant_idx(gidx[0]), .timeout(gto[0]));

  rr_hold_arbiter #(.NPORT(NP), .MODE(0), .MAX_HOLD(4)) u_to (
    .clock(clk), .reset(rst_n), .requests(requests), .enable(enable),
    .owner_release(rel), .grant_valid(gv[1]), .grant_onehot(goh[1]),
    .grant_idx(gidx[1]), .timeout(gto[1]));

  rr_hold_arbiter #(.NPORT(NP), .MODE(1), .MAX_HOLD(0)) u_fp (
    .clock(clk), .reset(rst_n), .requests(requests), .enable(enable),
    .owner_release(rel), .grant_valid(gv[2]), .grant_onehot(goh[2]),
    .grant_idx(gidx[2]), .timeout(gto[2]));

  function automatic int cfg_mode(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_hold(int k);
    return (k == 1) ? 4 : 0;
  endfunction

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      m_owner[k] = -1;
      m_last[k]  = NP - 1;
      m_idx[k]   = 0;
      m_held[k]  = 0;
      m_to[k]    = 1'b0;
    end
  endfunction

  // First requesting port in priority order; -1 if none.
  function automatic int mwin(int k, logic [NP-1:0] r);
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (cfg_mode(k) == 1) ? i : (m_last[k] + 1 + i) % NP;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  // One clock edge of the arbiter rules, in terms of owner and cycles held.
  function automatic void model_step(logic [NP-1:0] r, logic en, logic rl);
    for (int k = 0; k < NI; k++) begin
      int o;
      bit own_req, lim, ended;
      o       = m_owner[k];
      own_req = (o >= 0) ? r[o] : 1'b0;
      lim     = (o >= 0) && (cfg_hold(k) > 0) && (m_held[k] == cfg_hold(k));
      ended   = (o >= 0) && (rl || !own_req || lim);
      m_to[k] = ended && lim && !rl && own_req;
      if ((o < 0 || ended) && en && (r != '0)) begin
        m_owner[k] = mwin(k, r);
        m_last[k]  = m_owner[k];
        m_idx[k]   = m_owner[k];
        m_held[k]  = 1;
      end else if (ended) begin
        m_owner[k] = -1;
      end else if (o >= 0) begin
        m_held[k]++;
      end
    end
  endfunction

  function automatic void compare_all();
    for (int k = 0; k < NI; k++) begin
      logic [31:0] oh;
      oh = (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0;
      chk("valid",   k, 32'(gv[k]),   32'(m_owner[k] >= 0));
      chk("onehot",  k, 32'(goh[k]),  oh);
      chk("idx",     k, 32'(gidx[k]), 32'(m_idx[k]));
      chk("timeout", k, 32'(gto[k]),  32'(m_to[k]));
    end
  endfunction

  // Drive inputs, take one edge, then check everything 1 time unit later.
  task automatic step(input logic [NP-1:0] r, input logic en, input logic rl);
    requests = r;
    enable   = en;
    rel      = rl;
    @(posedge clk);
    model_step(r, en, rl);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    requests = '0;
    enable   = 1'b0;
    rel      = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int k = 0; k < NI; k++) chk("rst_valid", k, 32'(gv[k]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rot [4];
    int exp_tidx [9];
    int exp_tto [9];
    logic [NP-1:0] r;
    exp_rot  = '{2, 4, 1, 2};
    exp_tidx = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    exp_tto  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

    model_reset();
    do_reset();
    for (int k = 0; k < NI; k++) begin
      chk("rst_idx", k, 32'(gidx[k]), 32'd0);
      chk("rst_onehot", k, 32'(goh[k]), 32'd0);
    end

    // First grant, one cycle after the request is sampled.
    step(5'b10110, 1'b1, 1'b0);
    chk("first_idx", 0, 32'(gidx[0]), 32'd1);
    chk("first_onehot", 0, 32'(goh[0]), 32'b00010);
    chk("first_valid", 0, 32'(gv[0]), 32'd1);

    // Unlimited hold.
    for (int i = 0; i < 10; i++) begin
      step(5'b10110, 1'b1, 1'b0);
      chk("hold_idx", 0, 32'(gidx[0]), 32'd1);
    end

    // Rotation with release pulsed every grant, no idle bubbles.
    for (int i = 0; i < 4; i++) begin
      step(5'b10110, 1'b1, 1'b1);
      chk("rot_idx", 0, 32'(gidx[0]), 32'(exp_rot[i]));
      chk("rot_valid", 0, 32'(gv[0]), 32'd1);
    end

    // Owner drops its request with nobody else pending.
    step(5'b00000, 1'b1, 1'b0);
    chk("drop_valid", 0, 32'(gv[0]), 32'd0);
    chk("drop_onehot", 0, 32'(goh[0]), 32'd0);
    chk("drop_idx", 0, 32'(gidx[0]), 32'd2);
    step(5'b00100, 1'b1, 1'b0);
    chk("regrant_idx", 0, 32'(gidx[0]), 32'd2);
    chk("regrant_valid", 0, 32'(gv[0]), 32'd1);

    // Hold limit of 4 on instance 1; enable low first keeps it idle.
    do_reset();
    step(5'b00011, 1'b0, 1'b0);
    chk("en_low_valid", 1, 32'(gv[1]), 32'd0);
    for (int i = 0; i < 9; i++) begin
      step(5'b00011, 1'b1, 1'b0);
      chk("to_idx", 1, 32'(gidx[1]), 32'(exp_tidx[i]));
      chk("to_pulse", 1, 32'(gto[1]), 32'(exp_tto[i]));
    end

    // Fixed priority, then reset in the middle of a grant.
    do_reset();
    step(5'b11000, 1'b1, 1'b0);
    chk("fp_idx_a", 2, 32'(gidx[2]), 32'd3);
    step(5'b11001, 1'b1, 1'b1);
    chk("fp_idx_b", 2, 32'(gidx[2]), 32'd0);
    chk("fp_valid_b", 2, 32'(gv[2]), 32'd1);
    step(5'b11001, 1'b1, 1'b0);
    do_reset();
    step(5'b11111, 1'b1, 1'b0);
    chk("post_rst_fp", 2, 32'(gidx[2]), 32'd0);
    chk("post_rst_rr", 0, 32'(gidx[0]), 32'd0);

    // Randomised traffic with sticky requests and occasional resets.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      if ($urandom_range(0, 9) < 3) r = NP'($urandom_range(0, 31));
      else if ($urandom_range(0, 9) == 0) r[$urandom_range(0, NP - 1)] = 1'b0;
      step(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
